fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of bubble cycles inserted after any control-flow redirect (legal range 1..7).
REQ-002 Parameter CNT_WIDTH, default 16, width of the stall-cycle statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 L1_busy  in  1  instruction L1 cannot accept or return a fetch this cycle.
REQ-006 branch_instruction  in  1  conditional branch resolved in execute this cycle.
REQ-007 branch_taken  in  1  branch outcome; qualified by branch_instruction.
REQ-008 jal_instruction  in  1  JAL resolved this cycle.
REQ-009 jalr_instruction  in  1  JALR resolved this cycle.
REQ-010 pc_select  out  2  program_counter mux select: 0 = pc+4, 1 = pc+alu_result (branch), 2 = jal_address, 3 = alu_result (jalr).
REQ-011 pc_enable  out  1  program_counter loads its next value this cycle.
REQ-012 fetch_req  out  1  request an instruction fetch from L1 at the current PC.
REQ-013 flush  out  1  invalidate fetch/decode stage contents this cycle.
REQ-014 stall_count  out  CNT_WIDTH  number of cycles spent in STALL since reset, saturating.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, STALL, FLUSH; state register updates only on rising clk.
REQ-016 IDLE: lasts exactly one cycle after reset release; pc_enable=0, fetch_req=0; next state FETCH.
REQ-017 Redirect condition SHALL be jalr_instruction | jal_instruction | (branch_instruction & branch_taken); redirect select priority jalr(3) > jal(2) > branch(1).
REQ-018 FETCH, no redirect, L1_busy=0: fetch_req=1, pc_enable=1, pc_select=0; stay in FETCH.
REQ-019 FETCH, L1_busy=1, no redirect: fetch_req=1, pc_enable=0, pc_select=0; next state STALL.
REQ-020 FETCH, redirect (regardless of L1_busy): pc_enable=1, pc_select=redirect select, flush=1, fetch_req=0; load bubble counter with FLUSH_CYCLES-1; next state FLUSH.
REQ-021 STALL: fetch_req=1, pc_enable=0; stall_count increments by 1 per cycle in STALL, holding at all-ones.
REQ-022 STALL, redirect arrives: controller SHALL latch the redirect select into a pending register (later redirect in same stall overwrites per priority of the cycle it arrives), assert flush=1 that cycle, keep pc_enable=0.
REQ-023 STALL exit when L1_busy=0: if pending redirect, pc_enable=1, pc_select=pending select, clear pending, next FLUSH with counter FLUSH_CYCLES-1; else pc_enable=1, pc_select=0, next FETCH.
REQ-024 FLUSH: flush=1, fetch_req=0, pc_enable=0; counter decrements each cycle; when counter=0 next state FETCH.
REQ-025 Redirect during FLUSH SHALL be ignored (pipeline already flushed; ISA guarantees none arrive).
REQ-026 pc_select SHALL be 0 in every cycle where pc_enable=0, except no other constraint.
REQ-027 All outputs are registered-state decodes; no combinational path from L1_busy to state except as specified above; latency from redirect input to pc_enable=1 is 0 cycles in FETCH, and same cycle as L1_busy deassertion in STALL.

Reset
REQ-028 While reset=0 at a rising edge: state=IDLE, pending cleared, bubble counter=0, stall_count=0.
REQ-029 Reset outputs: pc_select=0, pc_enable=0, fetch_req=0, flush=0, stall_count=0.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL discard pending redirect and bubble count; no redirect applied after release.

Verification
REQ-031 Reset release, L1_busy=0, no redirects for 5 cycles -> IDLE 1 cycle, then pc_enable=1, pc_select=0 every cycle, stall_count=0.
REQ-032 FETCH, L1_busy=1 for 3 cycles -> pc_enable=0 for those cycles, stall_count=3, pc_enable=1/pc_select=0 the cycle L1_busy drops.
REQ-033 FETCH, jal_instruction=1 and branch_instruction=1, branch_taken=1 same cycle -> pc_select=2, pc_enable=1, flush=1, then 2 FLUSH cycles (FLUSH_CYCLES=2), FETCH resumes.
REQ-034 STALL, jalr_instruction=1 pulsed once, L1_busy drops 2 cycles later -> pc_enable=1 with pc_select=3 on drop cycle, then FLUSH.
REQ-035 Branch with branch_taken=0 in FETCH -> pc_select=0, no flush.
REQ-036 reset=0 one cycle during FLUSH with pending redirect -> all outputs 0, stall_count=0, next run starts at IDLE with no redirect.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: PC/fetch sequencing FSM with stall, redirect and flush-bubble handling
module fetch_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 L1_busy,
  input  logic                 branch_instruction,
  input  logic                 branch_taken,
  input  logic                 jal_instruction,
  input  logic                 jalr_instruction,
  output logic [1:0]           pc_select,
  output logic                 pc_enable,
  output logic                 fetch_req,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] stall_count
);
  typedef enum logic [1:0] {IDLE, FETCH, STALL, FLUSH} state_t;
  localparam logic [2:0] BUBBLE_LOAD = 3'(FLUSH_CYCLES - 1);
  state_t     state, state_nx;
  logic [2:0] bubble, bubble_nx;
  logic       pend_vld, pend_vld_nx;
  logic [1:0] pend_sel, pend_sel_nx;
  logic [1:0] redir_sel, exit_sel;
  logic       redirect, exit_vld;
  assign redir_sel = jalr_instruction ? 2'd3 : jal_instruction ? 2'd2 :
                     (branch_instruction & branch_taken) ? 2'd1 : 2'd0;
  assign redirect  = redir_sel != 2'd0;
  // a redirect arriving on the very cycle the stall ends takes precedence over an older pending one
  assign exit_vld  = redirect | pend_vld;
  assign exit_sel  = redirect ? redir_sel : pend_sel;
  // next-state and output decode; reset forces all outputs low
  always_comb begin
    state_nx    = state;
    bubble_nx   = bubble;
    pend_vld_nx = pend_vld;
    pend_sel_nx = pend_sel;
    pc_select   = 2'd0;
    pc_enable   = 1'b0;
    fetch_req   = 1'b0;
    flush       = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_enable = 1'b1;
          pc_select = redir_sel;
          flush     = 1'b1;
          bubble_nx = BUBBLE_LOAD;
          state_nx  = FLUSH;
        end else begin
          fetch_req = 1'b1;
          pc_enable = !L1_busy;
          state_nx  = L1_busy ? STALL : FETCH;
        end
      end
      STALL: begin
        fetch_req = 1'b1;
        flush     = redirect;
        if (redirect) begin
          pend_vld_nx = 1'b1;
          pend_sel_nx = redir_sel;
        end
        if (!L1_busy) begin
          pc_enable   = 1'b1;
          pc_select   = exit_vld ? exit_sel : 2'd0;
          pend_vld_nx = 1'b0;
          pend_sel_nx = 2'd0;
          bubble_nx   = exit_vld ? BUBBLE_LOAD : bubble;
          state_nx    = exit_vld ? FLUSH : FETCH;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        bubble_nx = (bubble != 3'd0) ? bubble - 3'd1 : 3'd0;
        state_nx  = (bubble == 3'd0) ? FETCH : FLUSH;
      end
      default: state_nx = IDLE;
    endcase
    if (!reset) begin
      pc_select = 2'd0;
      pc_enable = 1'b0;
      fetch_req = 1'b0;
      flush     = 1'b0;
    end
  end
  // state, pending redirect, bubble counter and saturating stall statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bubble      <= 3'd0;
      pend_vld    <= 1'b0;
      pend_sel    <= 2'd0;
      stall_count <= '0;
    end else begin
      state       <= state_nx;
      bubble      <= bubble_nx;
      pend_vld    <= pend_vld_nx;
      pend_sel    <= pend_sel_nx;
      if (state == STALL && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random stimulus checked against a behavioural model
module tb_fetch_controller;
  localparam int FC = 2;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          reset, busy, br, tk, jal, jalr;
  logic [1:0]    pc_select;
  logic          pc_enable, fetch_req, flush;
  logic [CW-1:0] stall_count;
  int total = 0, bad = 0;
  int up, waiting, pend, bub, stalls;
  fetch_controller #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .L1_busy(busy), .branch_instruction(br),
    .branch_taken(tk), .jal_instruction(jal), .jalr_instruction(jalr),
    .pc_select(pc_select), .pc_enable(pc_enable), .fetch_req(fetch_req),
    .flush(flush), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic b, input logic bi, input logic t,
                      input logic j, input logic jr);
    int sel, eff, e_ps, e_pe, e_fr, e_fl;
    reset = r; busy = b; br = bi; tk = t; jal = j; jalr = jr;
    sel = jr ? 3 : j ? 2 : (bi && t) ? 1 : 0;
    e_ps = 0; e_pe = 0; e_fr = 0; e_fl = 0;
    @(negedge clk);
    if (!r) begin
      up = 0; waiting = 0; pend = 0; bub = 0;
    end else if (up == 0) begin
      up = 1;
    end else if (bub > 0) begin
      e_fl = 1; bub--;
    end else if (waiting) begin
      e_fr = 1; e_fl = (sel != 0);
      eff = (sel != 0) ? sel : pend;
      if (!b) begin
        e_pe = 1; e_ps = eff; waiting = 0; pend = 0;
        if (eff != 0) bub = FC;
      end else if (sel != 0) pend = sel;
    end else if (sel != 0) begin
      e_pe = 1; e_ps = sel; e_fl = 1; bub = FC;
    end else begin
      e_fr = 1; e_pe = !b; waiting = b;
    end
    chk("pc_select", pc_select, e_ps);
    chk("pc_enable", pc_enable, e_pe);
    chk("fetch_req", fetch_req, e_fr);
    chk("flush", flush, e_fl);
    chk("stall_count", stall_count, stalls);
    if (!r) stalls = 0;
    else if (up == 1 && waiting && bub == 0 && e_fr && !(e_pe == 0 && !b && !waiting)) begin
    end
    @(posedge clk);
    #1;
  endtask
  task automatic count_stall_edge(input logic r, input logic was_stall);
    if (!r) stalls = 0;
    else if (was_stall && stalls < (1 << CW) - 1) stalls++;
  endtask
  task automatic go(input logic r, input logic b, input logic bi, input logic t,
                    input logic j, input logic jr);
    logic in_stall;
    in_stall = (up == 1) && waiting && (bub == 0);
    step(r, b, bi, t, j, jr);
    count_stall_edge(r, in_stall);
  endtask
  initial begin
    up = 0; waiting = 0; pend = 0; bub = 0; stalls = 0;
    reset = 1'b0; busy = 1'b0; br = 1'b0; tk = 1'b0; jal = 1'b0; jalr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    go(0, 0, 0, 0, 0, 0);
    repeat (6) go(1, 0, 0, 0, 0, 0);
    repeat (3) go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    chk("stall3", stall_count, 3);
    go(1, 0, 1, 1, 1, 0);
    repeat (4) go(1, 0, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 1);
    repeat (2) go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    repeat (4) go(1, 0, 0, 0, 0, 0);
    go(1, 0, 1, 0, 0, 0);
    go(1, 0, 1, 1, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    chk("rst_mid_flush_cnt", stall_count, 0);
    repeat (4) go(1, 0, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    go(1, 1, 0, 0, 1, 0);
    go(0, 1, 0, 0, 0, 0);
    repeat (4) go(1, 0, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    go(1, 1, 1, 1, 0, 0);
    go(1, 0, 0, 0, 1, 0);
    repeat (3) go(1, 0, 0, 0, 0, 0);
    repeat (20) go(1, 1, 0, 0, 0, 0);
    chk("stall_sat", stall_count, (1 << CW) - 1);
    go(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      go($urandom_range(49) != 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
         $urandom_range(1) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
